// File: rtl/stream_gearbox_if.sv
// Strobe-stream bundle between a word source, the gearbox and a word sink.
interface stream_gearbox_if #(
    parameter int unsigned IN_LEN  = 8,
    parameter int unsigned OUT_LEN = 12
);
    logic               inclk;
    logic [IN_LEN-1:0]  in;
    logic               done_in;
    logic               in_ready;
    logic               outclk;
    logic [OUT_LEN-1:0] out;
    logic               done_out;
    logic               overflow;
    logic               idle;

    // Source side: presents words and end-of-stream, observes status.
    modport master (
        output inclk, in, done_in,
        input  in_ready, outclk, out, done_out, overflow, idle
    );

    // Gearbox side.
    modport slave (
        input  inclk, in, done_in,
        output in_ready, outclk, out, done_out, overflow, idle
    );
endinterface

// File: rtl/stream_gearbox.sv
// Width converter for strobed word streams with flush, backpressure and overflow flag.
// Bits are kept internally in MSB-first order (oldest bit highest); LSB-first mode
// bit-reverses each word on the way in and on the way out.
module stream_gearbox #(
    parameter int unsigned IN_LEN    = 8,
    parameter int unsigned OUT_LEN   = 12,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic              clk,
    input logic              reset,
    stream_gearbox_if.slave  bus
);
    localparam int unsigned W  = IN_LEN + OUT_LEN;
    localparam int unsigned CW = $clog2(W + 1);
    localparam logic [CW-1:0] OutLenC = CW'(OUT_LEN);
    localparam logic [CW-1:0] InLenC  = CW'(IN_LEN);

    logic [W-1:0]       acc_q, acc_d, acc_bits;
    logic [CW-1:0]      cnt_q, cnt_d, acc_cnt;
    logic               flush_q, flush_d, flush_act;
    logic [OUT_LEN-1:0] out_q, out_d, word, word_ord;
    logic               outclk_q, outclk_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               in_ready, accept;
    logic [IN_LEN-1:0]  in_bits;

    assign in_ready     = !flush_q && (cnt_q <= OutLenC);
    assign accept       = bus.inclk && in_ready;
    assign bus.in_ready = in_ready;
    assign bus.outclk   = outclk_q;
    assign bus.out      = out_q;
    assign bus.done_out = done_q;
    assign bus.overflow = ovf_q;
    assign bus.idle     = (cnt_q == '0) && !flush_q;

    // Put the incoming word into internal (earliest-bit-first = MSB) order.
    always_comb begin
        in_bits = '0;
        for (int i = 0; i < int'(IN_LEN); i++) begin
            in_bits[i] = MSB_FIRST ? bus.in[i] : bus.in[int'(IN_LEN) - 1 - i];
        end
    end

    // Accumulate, pick the oldest OUT_LEN bits or the zero-padded remainder on flush.
    always_comb begin
        acc_bits  = accept ? {acc_q[OUT_LEN-1:0], in_bits} : acc_q;
        acc_cnt   = cnt_q + (accept ? InLenC : '0);
        flush_act = flush_q || bus.done_in;
        acc_d     = acc_bits;
        cnt_d     = acc_cnt;
        flush_d   = flush_act;
        outclk_d  = 1'b0;
        done_d    = 1'b0;
        word      = '0;
        ovf_d     = ovf_q || (bus.inclk && !in_ready);
        if (acc_cnt >= OutLenC) begin
            word     = OUT_LEN'(acc_bits >> (acc_cnt - OutLenC));
            outclk_d = 1'b1;
            cnt_d    = acc_cnt - OutLenC;
        end else if (flush_act && acc_cnt != '0) begin
            // Remainder lands in the top bits; the low (latest) positions are zero.
            word     = OUT_LEN'(acc_bits << (OutLenC - acc_cnt));
            outclk_d = 1'b1;
            cnt_d    = '0;
        end else if (flush_act) begin
            done_d  = 1'b1;
            flush_d = 1'b0;
        end
    end

    // Map the internal word back to the external bit order; hold out between words.
    always_comb begin
        word_ord = '0;
        for (int i = 0; i < int'(OUT_LEN); i++) begin
            word_ord[i] = MSB_FIRST ? word[i] : word[int'(OUT_LEN) - 1 - i];
        end
        out_d = outclk_d ? word_ord : out_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            flush_q  <= 1'b0;
            out_q    <= '0;
            outclk_q <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            flush_q  <= flush_d;
            out_q    <= out_d;
            outclk_q <= outclk_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule

// File: tb/tb_stream_gearbox.sv
// Directed bench for three gearbox configurations: 8->12 MSB, 2->8 LSB, 8->2 LSB.
module tb_stream_gearbox;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    stream_gearbox_if #(.IN_LEN(8), .OUT_LEN(12)) if_a ();
    stream_gearbox_if #(.IN_LEN(2), .OUT_LEN(8))  if_b ();
    stream_gearbox_if #(.IN_LEN(8), .OUT_LEN(2))  if_c ();

    stream_gearbox #(.IN_LEN(8), .OUT_LEN(12), .MSB_FIRST(1'b1)) u_a (
        .clk(clk), .reset(reset), .bus(if_a.slave)
    );
    stream_gearbox #(.IN_LEN(2), .OUT_LEN(8), .MSB_FIRST(1'b0)) u_b (
        .clk(clk), .reset(reset), .bus(if_b.slave)
    );
    stream_gearbox #(.IN_LEN(8), .OUT_LEN(2), .MSB_FIRST(1'b0)) u_c (
        .clk(clk), .reset(reset), .bus(if_c.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expect a dibit on C this cycle.
    task automatic chk_c(input string tag, input logic [1:0] exp);
        check({tag, "_outclk"}, 64'(if_c.outclk), 64'd1);
        check({tag, "_out"}, 64'(if_c.out), 64'(exp));
    endtask

    initial begin
        if_a.inclk = 0; if_a.in = '0; if_a.done_in = 0;
        if_b.inclk = 0; if_b.in = '0; if_b.done_in = 0;
        if_c.inclk = 0; if_c.in = '0; if_c.done_in = 0;
        reset = 1;
        step(); step();
        check("rst_in_ready", 64'(if_a.in_ready), 64'd1);
        check("rst_idle", 64'(if_a.idle), 64'd1);
        check("rst_outclk", 64'(if_a.outclk), 64'd0);
        check("rst_out", 64'(if_a.out), 64'd0);
        check("rst_done_out", 64'(if_a.done_out), 64'd0);
        check("rst_overflow", 64'(if_a.overflow), 64'd0);
        reset = 0;
        step();

        // 1: 8->12 MSB, AB CD EF -> ABC, DEF
        if_a.inclk = 1; if_a.in = 8'hAB; step();
        check("t1_no_out", 64'(if_a.outclk), 64'd0);
        if_a.in = 8'hCD; step();
        check("t1_outclk1", 64'(if_a.outclk), 64'd1);
        check("t1_out1", 64'(if_a.out), 64'hABC);
        if_a.in = 8'hEF; step();
        check("t1_outclk2", 64'(if_a.outclk), 64'd1);
        check("t1_out2", 64'(if_a.out), 64'hDEF);
        if_a.inclk = 0; step();
        check("t1_outclk_end", 64'(if_a.outclk), 64'd0);
        check("t1_idle", 64'(if_a.idle), 64'd1);

        // 2: 2->8 LSB, 01 10 11 00 -> 39
        if_b.inclk = 1; if_b.in = 2'b01; step();
        if_b.in = 2'b10; step();
        if_b.in = 2'b11; step();
        check("t2_no_out", 64'(if_b.outclk), 64'd0);
        if_b.in = 2'b00; step();
        check("t2_outclk", 64'(if_b.outclk), 64'd1);
        check("t2_out", 64'(if_b.out), 64'h39);
        // Flush of a single dibit on LSB-first pads the MSBs.
        if_b.in = 2'b11; step();
        if_b.inclk = 0; if_b.done_in = 1; step();
        if_b.done_in = 0;
        check("t2_flush_outclk", 64'(if_b.outclk), 64'd1);
        check("t2_flush_out", 64'(if_b.out), 64'h03);
        step();
        check("t2_done_out", 64'(if_b.done_out), 64'd1);

        // 3: 8->2 LSB, B4 -> 00 01 11 10, then 1B back-to-back -> 11 10 01 00
        if_c.inclk = 1; if_c.in = 8'hB4; step();
        if_c.inclk = 0;
        chk_c("t3_d0", 2'b00);
        check("t3_rdy_cnt6", 64'(if_c.in_ready), 64'd0);
        step();
        chk_c("t3_d1", 2'b01);
        check("t3_rdy_cnt4", 64'(if_c.in_ready), 64'd0);
        step();
        chk_c("t3_d2", 2'b11);
        check("t3_rdy_cnt2", 64'(if_c.in_ready), 64'd1);
        if_c.inclk = 1; if_c.in = 8'h1B; step();
        if_c.inclk = 0;
        chk_c("t3_d3", 2'b10);
        step(); chk_c("t3_d4", 2'b11);
        step(); chk_c("t3_d5", 2'b10);
        step(); chk_c("t3_d6", 2'b01);
        step(); chk_c("t3_d7", 2'b00);
        step();
        check("t3_outclk_end", 64'(if_c.outclk), 64'd0);
        check("t3_idle", 64'(if_c.idle), 64'd1);
        check("t3_no_overflow", 64'(if_c.overflow), 64'd0);

        // 4: 8->12 MSB, 5A then done_in -> 5A0, done_out next cycle
        if_a.inclk = 1; if_a.in = 8'h5A; step();
        if_a.inclk = 0; if_a.done_in = 1; step();
        if_a.done_in = 0;
        check("t4_outclk", 64'(if_a.outclk), 64'd1);
        check("t4_out", 64'(if_a.out), 64'h5A0);
        check("t4_done_early", 64'(if_a.done_out), 64'd0);
        check("t4_flush_ready", 64'(if_a.in_ready), 64'd0);
        step();
        check("t4_done_out", 64'(if_a.done_out), 64'd1);
        check("t4_outclk_off", 64'(if_a.outclk), 64'd0);
        step();
        check("t4_done_pulse", 64'(if_a.done_out), 64'd0);
        check("t4_idle", 64'(if_a.idle), 64'd1);
        if_a.done_in = 1; step();
        if_a.done_in = 0;
        check("t4_empty_done", 64'(if_a.done_out), 64'd1);
        check("t4_empty_no_out", 64'(if_a.outclk), 64'd0);
        step();
        check("t4_empty_done_end", 64'(if_a.done_out), 64'd0);

        // 5: 8->2 LSB, inclk held high through in_ready low
        if_c.inclk = 1; if_c.in = 8'hB4; step();
        chk_c("t5_d0", 2'b00);
        check("t5_ovf0", 64'(if_c.overflow), 64'd0);
        if_c.in = 8'hFF; step();
        chk_c("t5_d1", 2'b01);
        check("t5_ovf1", 64'(if_c.overflow), 64'd1);
        step();
        chk_c("t5_d2", 2'b11);
        if_c.in = 8'h1B; step();
        if_c.inclk = 0;
        chk_c("t5_d3", 2'b10);
        step(); chk_c("t5_d4", 2'b11);
        step(); chk_c("t5_d5", 2'b10);
        step(); chk_c("t5_d6", 2'b01);
        step(); chk_c("t5_d7", 2'b00);
        step();
        check("t5_no_extra", 64'(if_c.outclk), 64'd0);
        check("t5_ovf_sticky", 64'(if_c.overflow), 64'd1);

        // 6: 8->12, 11 then reset, then AB CD -> ABC
        if_a.inclk = 1; if_a.in = 8'h11; step();
        if_a.inclk = 0; reset = 1; step();
        reset = 0;
        check("t6_idle", 64'(if_a.idle), 64'd1);
        check("t6_ovf_cleared", 64'(if_c.overflow), 64'd0);
        if_a.inclk = 1; if_a.in = 8'hAB; step();
        check("t6_no_out", 64'(if_a.outclk), 64'd0);
        if_a.in = 8'hCD; step();
        if_a.inclk = 0;
        check("t6_outclk", 64'(if_a.outclk), 64'd1);
        check("t6_out", 64'(if_a.out), 64'hABC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
